// File: rtl/xnor_pkg.sv
// Shared constants and FSM state encoding for the XNOR stream driver and its result packer.
package xnor_pkg;

    localparam int KERNEL_SIZE    = 9;
    localparam int RELU_THRESHOLD = 5;
    localparam int OUT_WORD_W     = 8;
    localparam int WIN_CNT_W      = 16;
    localparam int BIT_IDX_W      = $clog2(OUT_WORD_W);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/xnor_result_packer.sv
// Collects popcount result bits LSB first into output words; emits a word when full or
// when the job's final bit arrives (zero-padded above the last valid bit).
module xnor_result_packer
    import xnor_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  bit_valid,
    input  logic                  bit_data,
    input  logic                  bit_last,
    output logic                  res_valid,
    output logic [OUT_WORD_W-1:0] res_data,
    output logic                  res_last
);

    logic [OUT_WORD_W-1:0] shreg_q, shreg_d;
    logic [BIT_IDX_W-1:0]  idx_q, idx_d;
    logic                  res_valid_q, res_valid_d;
    logic [OUT_WORD_W-1:0] res_data_q, res_data_d;
    logic                  res_last_q, res_last_d;
    logic [OUT_WORD_W-1:0] word;

    always_comb begin
        shreg_d     = shreg_q;
        idx_d       = idx_q;
        res_valid_d = 1'b0;
        res_data_d  = res_data_q;
        res_last_d  = 1'b0;
        word        = shreg_q | (OUT_WORD_W'(bit_data) << idx_q);
        if (clear) begin
            shreg_d = '0;
            idx_d   = '0;
        end else if (bit_valid) begin
            // Upper bits of shreg are always zero, so a short final word comes out padded.
            if ((idx_q == BIT_IDX_W'(OUT_WORD_W - 1)) || bit_last) begin
                res_valid_d = 1'b1;
                res_data_d  = word;
                res_last_d  = bit_last;
                shreg_d     = '0;
                idx_d       = '0;
            end else begin
                shreg_d = word;
                idx_d   = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            shreg_q     <= '0;
            idx_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_last_q  <= 1'b0;
        end else begin
            shreg_q     <= shreg_d;
            idx_q       <= idx_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_last_q  <= res_last_d;
        end
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_last  = res_last_q;

endmodule

// File: rtl/xnor_stream_driver.sv
// Job sequencer feeding one weight and a stream of pixel windows to a popcount unit,
// and packing the returned result bits into output words.
module xnor_stream_driver
    import xnor_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WIN_CNT_W-1:0]   num_windows,
    input  logic                   wt_valid,
    input  logic [KERNEL_SIZE-1:0] wt_data,
    output logic                   wt_ready,
    input  logic                   px_valid,
    input  logic [KERNEL_SIZE-1:0] px_data,
    output logic                   px_ready,
    output logic                   weight_wr,
    output logic [KERNEL_SIZE-1:0] weight_out,
    output logic                   input_plugin,
    output logic [KERNEL_SIZE-1:0] pixels_out,
    input  logic                   pop_ready,
    input  logic                   pop_result,
    output logic                   res_valid,
    output logic [OUT_WORD_W-1:0]  res_data,
    output logic                   res_last,
    output logic                   busy,
    output logic                   done
);

    state_t                 state_q, state_d;
    logic [WIN_CNT_W-1:0]   n_q, n_d;
    logic [WIN_CNT_W-1:0]   issued_q, issued_d;
    logic [WIN_CNT_W-1:0]   received_q, received_d;
    logic                   weight_wr_q, weight_wr_d;
    logic [KERNEL_SIZE-1:0] weight_out_q, weight_out_d;
    logic                   input_plugin_q, input_plugin_d;
    logic [KERNEL_SIZE-1:0] pixels_out_q, pixels_out_d;
    logic                   wt_ready_q, wt_ready_d;
    logic                   px_ready_q, px_ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic wt_hs, px_hs, pop_acc, pop_last, pack_clear;

    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        issued_d       = issued_q;
        received_d     = received_q;
        weight_wr_d    = 1'b0;
        weight_out_d   = weight_out_q;
        input_plugin_d = 1'b0;
        pixels_out_d   = pixels_out_q;
        pack_clear     = 1'b0;

        wt_hs    = wt_valid & wt_ready_q;
        px_hs    = px_valid & px_ready_q;
        pop_acc  = pop_ready && ((state_q == STREAM) || (state_q == DRAIN)) && (received_q < n_q);
        pop_last = pop_acc && ((received_q + 16'd1) == n_q);

        if (px_hs) begin
            input_plugin_d = 1'b1;
            pixels_out_d   = px_data;
            issued_d       = issued_q + 16'd1;
        end
        if (pop_acc) begin
            received_d = received_q + 16'd1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    n_d        = num_windows;
                    issued_d   = '0;
                    received_d = '0;
                    pack_clear = 1'b1;
                    state_d    = (num_windows == '0) ? DONE : LOAD_W;
                end
            end
            LOAD_W: begin
                if (wt_hs) begin
                    weight_wr_d  = 1'b1;
                    weight_out_d = wt_data;
                    state_d      = STREAM;
                end
            end
            STREAM: if (issued_q == n_q) state_d = DRAIN;
            // Look at the post-increment count so the final word and done stay one cycle apart.
            DRAIN:  if (received_d == n_q) state_d = FLUSH;
            FLUSH:  state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        wt_ready_d = (state_d == LOAD_W);
        // No window may be issued in the same cycle the weight is being written.
        px_ready_d = (state_d == STREAM) && (issued_d < n_d) && !weight_wr_d;
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= IDLE;
            n_q            <= '0;
            issued_q       <= '0;
            received_q     <= '0;
            weight_wr_q    <= 1'b0;
            weight_out_q   <= '0;
            input_plugin_q <= 1'b0;
            pixels_out_q   <= '0;
            wt_ready_q     <= 1'b0;
            px_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            issued_q       <= issued_d;
            received_q     <= received_d;
            weight_wr_q    <= weight_wr_d;
            weight_out_q   <= weight_out_d;
            input_plugin_q <= input_plugin_d;
            pixels_out_q   <= pixels_out_d;
            wt_ready_q     <= wt_ready_d;
            px_ready_q     <= px_ready_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    xnor_result_packer u_packer (
        .clock     (clock),
        .reset     (reset),
        .clear     (pack_clear),
        .bit_valid (pop_acc),
        .bit_data  (pop_result),
        .bit_last  (pop_last),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_last  (res_last)
    );

    assign wt_ready     = wt_ready_q;
    assign px_ready     = px_ready_q;
    assign weight_wr    = weight_wr_q;
    assign weight_out   = weight_out_q;
    assign input_plugin = input_plugin_q;
    assign pixels_out   = pixels_out_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_xnor_stream_driver.sv
// Directed bench for xnor_stream_driver with a behavioural popcount unit closing the loop.
module tb_xnor_stream_driver;
    import xnor_pkg::*;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   start;
    logic [WIN_CNT_W-1:0]   num_windows;
    logic                   wt_valid;
    logic [KERNEL_SIZE-1:0] wt_data;
    logic                   wt_ready;
    logic                   px_valid;
    logic [KERNEL_SIZE-1:0] px_data;
    logic                   px_ready;
    logic                   weight_wr;
    logic [KERNEL_SIZE-1:0] weight_out;
    logic                   input_plugin;
    logic [KERNEL_SIZE-1:0] pixels_out;
    logic                   pop_ready;
    logic                   pop_result;
    logic                   res_valid;
    logic [OUT_WORD_W-1:0]  res_data;
    logic                   res_last;
    logic                   busy;
    logic                   done;

    always #5 clock = ~clock;

    xnor_stream_driver dut (
        .clock(clock), .reset(reset), .start(start), .num_windows(num_windows),
        .wt_valid(wt_valid), .wt_data(wt_data), .wt_ready(wt_ready),
        .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
        .weight_wr(weight_wr), .weight_out(weight_out),
        .input_plugin(input_plugin), .pixels_out(pixels_out),
        .pop_ready(pop_ready), .pop_result(pop_result),
        .res_valid(res_valid), .res_data(res_data), .res_last(res_last),
        .busy(busy), .done(done)
    );

    // Popcount unit: result bit returns one cycle after the window is presented.
    logic [KERNEL_SIZE-1:0] w_m = '0;
    logic                   pop_m = 1'b0;
    logic                   res_m = 1'b0;
    logic                   stray = 1'b0;

    function automatic logic pop_bit(input logic [KERNEL_SIZE-1:0] p, input logic [KERNEL_SIZE-1:0] w);
        logic [KERNEL_SIZE-1:0] x;
        int c;
        x = ~(p ^ w);
        c = 0;
        for (int i = 0; i < KERNEL_SIZE; i++) c += int'(x[i]);
        return (c >= RELU_THRESHOLD);
    endfunction

    always @(posedge clock) begin
        if (weight_wr) w_m <= weight_out;
        pop_m <= input_plugin;
        res_m <= pop_bit(pixels_out, w_m);
    end

    assign pop_ready  = pop_m | stray;
    assign pop_result = res_m;

    // Monitor, sole writer of the event records below.
    int            cyc = 0;
    int            n_plug = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            last_word_cyc = 0;
    int            wt_rdy_cnt = 0;
    logic [7:0]    wd[$];
    logic          wl[$];

    always begin
        @(posedge clock);
        #1;
        cyc = cyc + 1;
        if (input_plugin) n_plug = n_plug + 1;
        if (res_valid) begin
            wd.push_back(res_data);
            wl.push_back(res_last);
            last_word_cyc = cyc;
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (wt_ready) wt_rdy_cnt = wt_rdy_cnt + 1;
    end

    int n_chk = 0;
    int n_fail = 0;
    int b_plug, b_words, b_done, b_wt, start_edge;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs_zero(input string tag);
        chk({tag, "_data"}, 32'({weight_out, pixels_out, res_data}), 32'h0);
        chk({tag, "_ctl"}, 32'({weight_wr, input_plugin, res_valid, res_last, busy, done, wt_ready, px_ready}), 32'h0);
    endtask

    task automatic snapshot();
        b_plug  = n_plug;
        b_words = wd.size();
        b_done  = done_cnt;
        b_wt    = wt_rdy_cnt;
    endtask

    // alt: odd windows are all-zero; toggle: px_valid every other cycle; restart: extra start mid-job.
    task automatic run_job(input int n, input bit alt, input bit toggle, input bit restart);
        int  k, cnt;
        bit  hs, pulsed;
        k = 0; cnt = 0; pulsed = 0;
        snapshot();
        num_windows = 16'(n);
        start       = 1'b1;
        wt_valid    = 1'b1;
        wt_data     = 9'h1FF;
        start_edge  = cyc + 1;
        @(negedge clock);
        start       = 1'b0;
        num_windows = 16'd5;
        while ((done_cnt == b_done) && (cnt < 400)) begin
            px_valid = toggle ? (cnt % 2 == 0) : 1'b1;
            px_data  = (alt && (k % 2 == 1)) ? 9'h000 : 9'h1FF;
            if (restart && (k == 2) && !pulsed) begin
                start = 1'b1; num_windows = 16'd3; pulsed = 1'b1;
            end else begin
                start = 1'b0;
            end
            hs = px_valid && px_ready;
            @(negedge clock);
            if (hs) k++;
            cnt++;
        end
        start = 1'b0; px_valid = 1'b0; wt_valid = 1'b0;
        chk("job_timeout", 32'(cnt >= 400), 32'h0);
        repeat (3) @(negedge clock);
    endtask

    initial begin
        int k, cnt;
        bit hs;
        reset = 1'b1; start = 1'b0; num_windows = '0;
        wt_valid = 1'b0; wt_data = '0; px_valid = 1'b0; px_data = '0;
        repeat (3) @(negedge clock);
        check_outs_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        // N=8, all-ones windows and weight: one full word, done right after it
        run_job(8, 1'b0, 1'b0, 1'b0);
        chk("n8_plugs", n_plug - b_plug, 8);
        chk("n8_words", wd.size() - b_words, 1);
        chk("n8_word0", 32'(wd[b_words]), 32'hFF);
        chk("n8_last0", 32'(wl[b_words]), 32'h1);
        chk("n8_done", done_cnt - b_done, 1);
        chk("n8_done_lat", done_cyc - last_word_cyc, 1);
        chk("n8_wt_rdy", wt_rdy_cnt - b_wt, 1);
        chk("n8_busy_after", 32'(busy), 32'h0);

        // N=10 alternating windows: 0x55 then padded 0x01 (last)
        run_job(10, 1'b1, 1'b0, 1'b0);
        chk("n10_plugs", n_plug - b_plug, 10);
        chk("n10_words", wd.size() - b_words, 2);
        chk("n10_word0", 32'(wd[b_words]), 32'h55);
        chk("n10_last0", 32'(wl[b_words]), 32'h0);
        chk("n10_word1", 32'(wd[b_words + 1]), 32'h01);
        chk("n10_last1", 32'(wl[b_words + 1]), 32'h1);
        chk("n10_done_lat", done_cyc - last_word_cyc, 1);

        // N=0: no weight read, no word, done in the cycle after start is taken
        run_job(0, 1'b0, 1'b0, 1'b0);
        chk("n0_wt_rdy", wt_rdy_cnt - b_wt, 0);
        chk("n0_words", wd.size() - b_words, 0);
        chk("n0_done", done_cnt - b_done, 1);
        chk("n0_done_cyc", done_cyc, start_edge);

        // N=16 with px_valid toggling: all windows issued, two full words
        run_job(16, 1'b0, 1'b1, 1'b0);
        chk("n16_plugs", n_plug - b_plug, 16);
        chk("n16_words", wd.size() - b_words, 2);
        chk("n16_word0", 32'(wd[b_words]), 32'hFF);
        chk("n16_last0", 32'(wl[b_words]), 32'h0);
        chk("n16_word1", 32'(wd[b_words + 1]), 32'hFF);
        chk("n16_last1", 32'(wl[b_words + 1]), 32'h1);

        // Reset after three issues, stray pop_ready in IDLE, then a fresh job
        snapshot();
        num_windows = 16'd8; start = 1'b1; wt_valid = 1'b1; wt_data = 9'h1FF;
        @(negedge clock);
        start = 1'b0;
        k = 0; cnt = 0;
        while ((k < 3) && (cnt < 100)) begin
            px_valid = 1'b1; px_data = 9'h1FF;
            hs = px_ready;
            @(negedge clock);
            if (hs) k++;
            cnt++;
        end
        chk("rst_issue_to", 32'(cnt >= 100), 32'h0);
        px_valid = 1'b0; wt_valid = 1'b0; reset = 1'b1; stray = 1'b1;
        @(negedge clock);
        check_outs_zero("mid_reset");
        reset = 1'b0;
        repeat (3) @(negedge clock);
        stray = 1'b0;
        @(negedge clock);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_words", wd.size() - b_words, 0);
        chk("rst_done", done_cnt - b_done, 0);
        run_job(8, 1'b0, 1'b0, 1'b0);
        chk("post_rst_words", wd.size() - b_words, 1);
        chk("post_rst_word0", 32'(wd[b_words]), 32'hFF);
        chk("post_rst_last0", 32'(wl[b_words]), 32'h1);
        chk("post_rst_done", done_cnt - b_done, 1);

        // start pulsed mid-job with a different count must not disturb the job
        run_job(8, 1'b0, 1'b0, 1'b1);
        chk("busy_start_plugs", n_plug - b_plug, 8);
        chk("busy_start_words", wd.size() - b_words, 1);
        chk("busy_start_word0", 32'(wd[b_words]), 32'hFF);
        chk("busy_start_done", done_cnt - b_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
